// File: rtl/vc_mem_copy_engine.sv
// vc_mem_copy_engine: val/rdy memory-request initiator that copies cfg_num words src -> dst.
// Message layout is {type, addr, len, data} for requests and {type, len, data} for responses.
`ifndef VC_MEM_MSGS_V
`define VC_MEM_MSGS_V
`define VC_MEM_REQ_MSG_TYPE_READ 1'd0
`define VC_MEM_REQ_MSG_TYPE_WRITE 1'd1
`define VC_MEM_RESP_MSG_TYPE_READ 1'd0
`define VC_MEM_RESP_MSG_TYPE_WRITE 1'd1
`define VC_MEM_MSG_LEN_SZ(d) $clog2((d)/8)
`define VC_MEM_REQ_MSG_SZ(a,d) (1+(a)+`VC_MEM_MSG_LEN_SZ(d)+(d))
`define VC_MEM_REQ_MSG_TYPE_FIELD(a,d) (`VC_MEM_REQ_MSG_SZ(a,d)-1)
`define VC_MEM_REQ_MSG_ADDR_FIELD(a,d) (`VC_MEM_REQ_MSG_SZ(a,d)-2):(`VC_MEM_MSG_LEN_SZ(d)+(d))
`define VC_MEM_REQ_MSG_LEN_FIELD(a,d) (`VC_MEM_MSG_LEN_SZ(d)+(d)-1):(d)
`define VC_MEM_REQ_MSG_DATA_FIELD(a,d) ((d)-1):0
`define VC_MEM_RESP_MSG_SZ(d) (1+`VC_MEM_MSG_LEN_SZ(d)+(d))
`define VC_MEM_RESP_MSG_TYPE_FIELD(d) (`VC_MEM_RESP_MSG_SZ(d)-1)
`define VC_MEM_RESP_MSG_LEN_FIELD(d) (`VC_MEM_MSG_LEN_SZ(d)+(d)-1):(d)
`define VC_MEM_RESP_MSG_DATA_FIELD(d) ((d)-1):0
`endif

module vc_mem_copy_engine #(
    parameter int p_addr_sz = 16,
    parameter int p_data_sz = 32,
    parameter int p_cnt_sz  = 16
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            cfg_val,
    output logic                                            cfg_rdy,
    input  logic [p_addr_sz-1:0]                            cfg_src,
    input  logic [p_addr_sz-1:0]                            cfg_dst,
    input  logic [p_cnt_sz-1:0]                             cfg_num,
    output logic                                            memreq_val,
    input  logic                                            memreq_rdy,
    output logic [`VC_MEM_REQ_MSG_SZ(p_addr_sz,p_data_sz)-1:0] memreq_msg,
    input  logic                                            memresp_val,
    output logic                                            memresp_rdy,
    input  logic [`VC_MEM_RESP_MSG_SZ(p_data_sz)-1:0]       memresp_msg,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            err
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP, DONE} state_t;

    localparam logic [p_addr_sz-1:0] STEP = p_addr_sz'(p_data_sz / 8);

    state_t               state_q;
    logic [p_addr_sz-1:0] src_q;
    logic [p_addr_sz-1:0] dst_q;
    logic [p_cnt_sz-1:0]  cnt_q;
    logic [p_data_sz-1:0] data_q;
    logic                 err_q;
    logic                 resp_type;
    logic                 unused_resp_len;

    assign resp_type       = memresp_msg[`VC_MEM_RESP_MSG_TYPE_FIELD(p_data_sz)];
    assign unused_resp_len = ^memresp_msg[`VC_MEM_RESP_MSG_LEN_FIELD(p_data_sz)];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cfg_val) begin
                    src_q   <= cfg_src;
                    dst_q   <= cfg_dst;
                    cnt_q   <= cfg_num;
                    err_q   <= 1'b0;
                    state_q <= (cfg_num == '0) ? DONE : RD_REQ;
                end
                RD_REQ: if (memreq_rdy) state_q <= RD_RESP;
                RD_RESP: if (memresp_val) begin
                    data_q  <= memresp_msg[`VC_MEM_RESP_MSG_DATA_FIELD(p_data_sz)];
                    err_q   <= (resp_type != `VC_MEM_RESP_MSG_TYPE_READ);
                    state_q <= (resp_type != `VC_MEM_RESP_MSG_TYPE_READ) ? DONE : WR_REQ;
                end
                WR_REQ: if (memreq_rdy) state_q <= WR_RESP;
                WR_RESP: if (memresp_val) begin
                    if (resp_type != `VC_MEM_RESP_MSG_TYPE_WRITE) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        src_q   <= src_q + STEP;
                        dst_q   <= dst_q + STEP;
                        cnt_q   <= cnt_q - p_cnt_sz'(1);
                        state_q <= (cnt_q == p_cnt_sz'(1)) ? DONE : RD_REQ;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_rdy     = (state_q == IDLE);
    assign memreq_val  = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign memresp_rdy = (state_q == RD_RESP) || (state_q == WR_RESP);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign err         = err_q;

    // Message is a pure decode of registered state, so it stays stable across request stalls.
    always_comb begin
        memreq_msg = '0;
        if (memreq_val) begin
            memreq_msg[`VC_MEM_REQ_MSG_TYPE_FIELD(p_addr_sz,p_data_sz)] =
                (state_q == WR_REQ) ? `VC_MEM_REQ_MSG_TYPE_WRITE : `VC_MEM_REQ_MSG_TYPE_READ;
            memreq_msg[`VC_MEM_REQ_MSG_ADDR_FIELD(p_addr_sz,p_data_sz)] =
                (state_q == WR_REQ) ? dst_q : src_q;
            memreq_msg[`VC_MEM_REQ_MSG_DATA_FIELD(p_addr_sz,p_data_sz)] =
                (state_q == WR_REQ) ? data_q : '0;
        end
    end
endmodule

// File: tb/tb_vc_mem_copy_engine.sv
// tb_vc_mem_copy_engine: scoreboarded bench with a behavioural vc memory responder.
// Request layout {type[50], addr[49:34], len[33:32], data[31:0]}; response {type[34], len, data}.
module tb_vc_mem_copy_engine;
    logic        clk;
    logic        reset;
    logic        cfg_val;
    logic        cfg_rdy;
    logic [15:0] cfg_src;
    logic [15:0] cfg_dst;
    logic [15:0] cfg_num;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [50:0] memreq_msg;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [34:0] memresp_msg;
    logic        busy;
    logic        done;
    logic        err;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_req = 0;
    bit          stall = 0;
    bit          inject = 0;
    logic [31:0] mem [logic [15:0]];
    logic [31:0] gold [logic [15:0]];
    logic [50:0] exp_q [$];

    vc_mem_copy_engine dut (
        .clk(clk), .reset(reset),
        .cfg_val(cfg_val), .cfg_rdy(cfg_rdy), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_num(cfg_num),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Responder: acts on negedges, so every handshake decision is made on settled DUT outputs.
    initial begin
        bit          pend, rf, sf, stalled;
        int          dly;
        logic [50:0] rq, held;
        logic        rtyp;
        logic [31:0] rdata;
        pend = 0; rf = 0; sf = 0; stalled = 0; dly = 0; rq = '0; held = '0;
        memreq_rdy = 0; memresp_val = 0; memresp_msg = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = 0; rf = 0; sf = 0; stalled = 0;
                memresp_val = 0; memreq_rdy = 0;
            end else begin
                if (sf) begin
                    memresp_val = 0;
                    pend = 0;
                end
                if (rf) begin
                    n_req++;
                    if (exp_q.size() > 0) chk("req_order", rq, exp_q.pop_front());
                    else chk("req_extra", exp_q.size(), 1);
                    if (rq[50]) begin
                        mem[rq[49:34]] = rq[31:0];
                        rtyp = 1'b1;
                        rdata = '0;
                    end else begin
                        rdata = mem.exists(rq[49:34]) ? mem[rq[49:34]] : 32'h0;
                        rtyp = 1'b0;
                        if (inject) begin
                            rtyp = 1'b1;
                            inject = 0;
                        end
                    end
                    memresp_msg = {rtyp, 2'b00, rdata};
                    pend = 1;
                    dly = stall ? int'($urandom_range(0, 10)) : 0;
                end
                if (stalled) begin
                    chk("hold_val", memreq_val, 1);
                    chk("hold_msg", memreq_msg, held);
                end
                if (pend && !memresp_val) begin
                    if (dly == 0) memresp_val = 1;
                    else dly--;
                end
                memreq_rdy = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
                rf = memreq_val && memreq_rdy;
                rq = memreq_msg;
                sf = memresp_val && memresp_rdy;
                stalled = memreq_val && !memreq_rdy;
                held = memreq_msg;
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [31:0] v);
        mem[a] = v;
        gold[a] = v;
    endtask

    task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        @(negedge clk);
        chk("cfg_rdy", cfg_rdy, 1);
        cfg_val = 1; cfg_src = s; cfg_dst = d; cfg_num = n;
        @(negedge clk);
        cfg_val = 0; cfg_src = '0; cfg_dst = '0; cfg_num = '0;
        chk("busy", busy, 1);
    endtask

    task automatic wait_done(output int k);
        k = 1;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n, input bit lat);
        int          k;
        logic [15:0] a, b;
        for (int i = 0; i < int'(n); i++) begin
            a = s + 16'(4 * i);
            b = d + 16'(4 * i);
            exp_q.push_back({1'b0, a, 2'b00, 32'h0});
            gold[b] = gold[a];
            exp_q.push_back({1'b1, b, 2'b00, gold[b]});
        end
        issue(s, d, n);
        wait_done(k);
        if (lat) chk("latency", k, 4 * int'(n) + 1);
        @(negedge clk);
        chk("done_pulse", {done, busy, cfg_rdy}, 3'b001);
    endtask

    task automatic readback(input logic [15:0] base, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(4 * i);
            chk("readback", mem.exists(a) ? mem[a] : 32'hx, gold[a]);
        end
    endtask

    initial begin
        int k;
        int nr;
        reset = 0; cfg_val = 0; cfg_src = '0; cfg_dst = '0; cfg_num = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {cfg_rdy, memreq_val, memresp_rdy, busy, done, err}, 6'b100000);
        chk("rst_msg", memreq_msg, 0);
        #2 reset = 1;

        preload(16'h0000, 32'h0a0b0c0d);
        preload(16'h0004, 32'h0e0f0102);
        preload(16'h0008, 32'hdeadbeef);
        preload(16'h000c, 32'h01020304);
        preload(16'hfffc, 32'h55aa33cc);
        preload(16'h0300, 32'h13572468);
        preload(16'h0304, 32'hcafef00d);

        copy(16'h0000, 16'h0100, 4, 1);
        readback(16'h0100, 4);

        for (int i = 0; i < 4; i++) mem[16'h0100 + 16'(4 * i)] = 32'h0;
        stall = 1;
        copy(16'h0000, 16'h0100, 4, 0);
        stall = 0;
        readback(16'h0100, 4);

        copy(16'hfffc, 16'h0200, 2, 1);
        readback(16'h0200, 2);

        nr = n_req;
        inject = 1;
        exp_q.push_back({1'b0, 16'h0000, 2'b00, 32'h0});
        issue(16'h0000, 16'h0500, 4);
        wait_done(k);
        chk("err_latency", k, 3);
        chk("err_set", err, 1);
        @(negedge clk);
        chk("err_sticky", {err, done, busy, cfg_rdy}, 4'b1001);
        chk("err_noreq", n_req - nr, 1);

        copy(16'h0000, 16'h0000, 0, 1);
        chk("err_clr", err, 0);
        chk("zero_noreq", n_req - nr, 1);

        exp_q.push_back({1'b0, 16'h0300, 2'b00, 32'h0});
        issue(16'h0300, 16'h0400, 4);
        k = 0;
        while (!(memreq_val && memreq_msg[50]) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("wr_req_seen", memreq_val && memreq_msg[50], 1);
        #2 reset = 0;
        #1;
        chk("rst_async", {memreq_val, busy, cfg_rdy, memresp_rdy, done, err}, 6'b001000);
        chk("rst_async_msg", memreq_msg, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1;
        chk("rst_abandon", exp_q.size(), 0);
        chk("rst_nowrite", mem.exists(16'h0400), 0);
        copy(16'h0304, 16'h0404, 1, 1);
        readback(16'h0404, 1);

        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/vc_mem_copy_engine.md
# vc_mem_copy_engine

Memory-request initiator that copies a block of words from one address range to another over the standard `vc` val/rdy memory request/response interface. It acts as the requester end of that interface: it drives `memreq` and consumes `memresp` against any `vc` memory responder, for example the single-port test memory. A small val/rdy command port starts each copy, and a one-cycle `done` pulse signals completion.

## Interface
- `p_addr_sz`, default 16: memory address width in bits.
- `p_data_sz`, default 32: memory data width in bits; must be a multiple of 8.
- `p_cnt_sz`, default 16: width of the word-count field.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (reset is asserted when `reset` = 0).
- `cfg_val`  in  1  command valid.
- `cfg_rdy`  out  1  command ready; high only in IDLE.
- `cfg_src`  in  `p_addr_sz`  source base address, word-aligned.
- `cfg_dst`  in  `p_addr_sz`  destination base address, word-aligned.
- `cfg_num`  in  `p_cnt_sz`  number of words to copy.
- `memreq_val`  out  1  request valid.
- `memreq_rdy`  in  1  request ready.
- `memreq_msg`  out  `VC_MEM_REQ_MSG_SZ(p_addr_sz,p_data_sz)`  request; fields are type, addr, len, data, built with the `VC_MEM_REQ_MSG_*_FIELD` macros.
- `memresp_val`  in  1  response valid.
- `memresp_rdy`  out  1  response ready.
- `memresp_msg`  in  `VC_MEM_RESP_MSG_SZ(p_data_sz)`  response; fields are type, len, data.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of every command.
- `err`  out  1  sticky response-type error flag.

## Operation
- FSM states: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP, DONE.
- IDLE:
  - A handshake (`cfg_val & cfg_rdy`) latches the source pointer, destination pointer and remaining count, and clears `err`.
  - The next state is RD_REQ, or DONE if `cfg_num` = 0.
- RD_REQ: drives type READ, addr = source pointer, len = 0 (full word), data = 0. On `memreq_rdy`, go to RD_RESP.
- RD_RESP:
  - On `memresp_val`, capture the data field into the data register and go to WR_REQ.
  - If the response type is not READ, set `err` and go to DONE instead.
- WR_REQ: drives type WRITE, addr = destination pointer, len = 0, data = data register. On `memreq_rdy`, go to WR_RESP.
- WR_RESP:
  - On `memresp_val`, advance both pointers by `p_data_sz/8`, decrement the count, and go to RD_REQ, or to DONE when the count reaches 0.
  - If the response type is not WRITE, set `err` and go to DONE.
- DONE: assert `done` for exactly one cycle, then return to IDLE.
- Pointer arithmetic is modulo 2^`p_addr_sz`, so a pointer past the top of memory wraps to 0. Count arithmetic is unsigned.
- At most one request is outstanding at any time.
- Only AMO-free READ/WRITE traffic is generated; len is always 0.
- `cfg_*` inputs are ignored outside IDLE.

## Timing
- Reset values: IDLE, `cfg_rdy` = 1, `memreq_val` = 0, `memresp_rdy` = 0, `busy` = 0, `done` = 0, `err` = 0, `memreq_msg` = 0.
- All outputs are decoded from registered state only; there is no combinational path from any input to any output.
- `memreq_val` is high exactly in RD_REQ and WR_REQ. `memresp_rdy` is high exactly in RD_RESP and WR_RESP.
- `memreq_msg` is held stable while `memreq_val & !memreq_rdy`.
- A response arriving in any other state is not accepted, because `memresp_rdy` = 0.
- Latency with zero-stall handshakes:
  - Each word takes 4 cycles.
  - A command accepted at edge N has its first `memreq_val` in cycle N+1.
  - `done` is high in cycle N+4·`cfg_num`+1.
  - For `cfg_num` = 0, `done` is high in cycle N+1.
- Stalls on `memreq_rdy` or `memresp_val` extend the corresponding state by any number of cycles without changing the sequence of requests.
- Reset mid-operation: all outputs return to their reset values immediately and asynchronously. Any in-flight transaction is abandoned; the responder must be reset together with this block.
- A new command can be accepted at the first edge after DONE, i.e. while back in IDLE.

## Test plan
- Zero-delay copy:
  - Stimulus: preload 0x0000/0x0004/0x0008/0x000c = 0x0a0b0c0d/0x0e0f0102/0xdeadbeef/0x01020304; command src = 0x0000, dst = 0x0100, num = 4.
  - Required response: the request order is rd 0x0000, wr 0x0100, rd 0x0004, wr 0x0104, and so on. `done` is high in cycle accept+17, and readback of 0x0100..0x010c matches the source words.
- Zero count: command num = 0 -> `done` is high in cycle accept+1, no `memreq_val` is ever asserted, and `err` = 0.
- Random stalls:
  - Stimulus: repeat the zero-delay copy with source delay 3 and sink delay 10 on the responder side.
  - Required response: `memreq_msg` is stable during every stall, the request sequence is identical, and the destination contents are identical.
- Wrap-around: command src = 0xfffc, dst = 0x0200, num = 2 -> the second read address is 0x0000, and the writes go to 0x0200/0x0204.
- Type error: the responder returns type WRITE to the first read -> `err` = 1 with `done` pulsing the next cycle and no further requests. The next accepted command clears `err` to 0.
- Reset mid-copy: drive `reset` low while in WR_REQ -> `memreq_val` and `busy` drop to 0 without waiting for a clock edge. After `reset` returns high, `cfg_rdy` = 1 and a fresh num = 1 copy completes correctly.
